// File: rtl/bt_pkg.sv
// bt_pkg: shared state, grant and line-ending encodings for the transmit scheduler
package bt_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    SEND  = 3'd3,
    CHECK = 3'd4,
    STALL = 3'd5
  } state_t;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_AT   = 2'b01;
  localparam logic [1:0] GNT_SEN  = 2'b10;
endpackage

// File: rtl/bt_tx_arb2.sv
// bt_tx_arb2: two-way round-robin pick; pointer moves to the other source when a packet ends or aborts
module bt_tx_arb2
  import bt_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       at_req,
  input  logic       sen_req,
  input  logic       adv,
  input  logic [1:0] done_gnt,
  output logic [1:0] pick
);
  logic ptr_sen;
  // pointer names the source that wins a tie; it flips away from whoever just finished
  always_ff @(posedge clock) begin
    if (reset) ptr_sen <= 1'b0;
    else if (adv) ptr_sen <= done_gnt == GNT_AT;
  end
  assign pick = (at_req && (!sen_req || !ptr_sen)) ? GNT_AT : sen_req ? GNT_SEN : GNT_NONE;
endmodule

// File: rtl/bt_tx_scheduler.sv
// bt_tx_scheduler: packet-granular sharing of one UART transmitter between the AT and sensor FIFOs
module bt_tx_scheduler
  import bt_pkg::*;
#(
  parameter int PKT_LEN = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       at_empty,
  output logic       at_rd_en,
  input  logic [7:0] at_data,
  input  logic       sen_empty,
  output logic       sen_rd_en,
  input  logic [7:0] sen_data,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic [1:0] grant,
  output logic       busy,
  output logic       pkt_done,
  output logic       timeout_err,
  input  logic       clear_err,
  output logic [2:0] state
);
  state_t st, nx;
  logic [7:0] prev, cnt;
  logic [15:0] stall;
  logic [1:0] pick;
  logic src_empty, eop, abort;
  assign src_empty = grant == GNT_AT ? at_empty : sen_empty;
  assign eop = grant == GNT_AT ? (tx_data == LF && prev == CR) : (cnt == 8'(PKT_LEN));
  assign abort = st == STALL && src_empty && stall == 16'(TIMEOUT - 1);
  bt_tx_arb2 u_arb (
    .clock(clock),
    .reset(reset),
    .at_req(!at_empty),
    .sen_req(!sen_empty),
    .adv((st == CHECK && eop) || abort),
    .done_gnt(grant),
    .pick(pick)
  );
  // state register
  always_ff @(posedge clock) begin
    if (reset) st <= IDLE;
    else st <= nx;
  end
  // next state and the strobes that are pure functions of the current state
  always_comb begin
    nx = st;
    at_rd_en = st == FETCH && grant == GNT_AT;
    sen_rd_en = st == FETCH && grant == GNT_SEN;
    tx_start = st == SEND;
    pkt_done = st == CHECK && eop;
    busy = st != IDLE;
    state = st;
    unique case (st)
      IDLE:    nx = (enable && pick != GNT_NONE) ? FETCH : IDLE;
      FETCH:   nx = LATCH;
      LATCH:   nx = SEND;
      SEND:    nx = tx_done ? CHECK : SEND;
      CHECK:   nx = eop ? IDLE : src_empty ? STALL : FETCH;
      STALL:   nx = !src_empty ? FETCH : abort ? IDLE : STALL;
      default: nx = IDLE;
    endcase
  end
  // grant, byte datapath, counters and the sticky timeout flag
  always_ff @(posedge clock) begin
    if (reset) begin
      grant <= GNT_NONE;
      tx_data <= 8'h00;
      prev <= 8'h00;
      cnt <= 8'h00;
      stall <= 16'h0000;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= abort || (timeout_err && !clear_err);
      unique case (st)
        IDLE: if (nx == FETCH) begin
          grant <= pick;
          cnt <= 8'h00;
          prev <= 8'h00;
        end
        LATCH: begin
          tx_data <= grant == GNT_AT ? at_data : sen_data;
          cnt <= cnt + 8'(cnt != 8'hFF);
        end
        CHECK: begin
          if (eop) grant <= GNT_NONE;
          else if (!src_empty) prev <= tx_data;
          else stall <= 16'h0000;
        end
        STALL: begin
          stall <= stall + 16'd1;
          if (abort) grant <= GNT_NONE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bt_tx_scheduler.sv
// tb_bt_tx_scheduler: FIFO/UART models with a packet-level arbitration scoreboard
module tb_bt_tx_scheduler;
  logic clock = 1'b0, reset = 1'b1, enable = 1'b0, clear_err = 1'b0, tx_done = 1'b0;
  logic at_empty = 1'b1, sen_empty = 1'b1;
  logic [7:0] at_data = 8'h00, sen_data = 8'h00;
  logic at_rd_en, sen_rd_en, tx_start, busy, pkt_done, timeout_err;
  logic [7:0] tx_data;
  logic [1:0] grant;
  logic [2:0] state;
  logic [7:0] at_q[$], sen_q[$], sent_b[$], exp_b[$], at_all[$], sen_all[$];
  logic [1:0] sent_s[$], exp_s[$];
  int at_len[$];
  int errors = 0, checks = 0, exp_ptr = 0;
  int cyc = 0, rises = 0, at_rds = 0, sen_rds = 0, pkts = 0, both_rd = 0, gap_bad = 0, bad_gnt = 0, last_done = -1;
  int ucnt = 0, udly = 1;
  logic prev_start = 1'b0;

  bt_tx_scheduler #(.PKT_LEN(8), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .at_empty(at_empty), .at_rd_en(at_rd_en), .at_data(at_data),
    .sen_empty(sen_empty), .sen_rd_en(sen_rd_en), .sen_data(sen_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .grant(grant), .busy(busy), .pkt_done(pkt_done),
    .timeout_err(timeout_err), .clear_err(clear_err), .state(state)
  );

  always #5 clock = ~clock;

  // FIFO read side: dout valid the cycle after rd_en
  always @(posedge clock) begin
    if (at_rd_en && at_q.size() > 0) at_data <= at_q.pop_front();
    if (sen_rd_en && sen_q.size() > 0) sen_data <= sen_q.pop_front();
  end
  always @(negedge clock) begin
    at_empty = at_q.size() == 0;
    sen_empty = sen_q.size() == 0;
  end

  // UART: random busy time, one-cycle done pulse, logs each byte with its grant
  always @(posedge clock) begin
    if (reset) begin
      tx_done <= 1'b0;
      ucnt = 0;
    end else if (tx_done) tx_done <= 1'b0;
    else if (tx_start) begin
      if (ucnt >= udly) begin
        tx_done <= 1'b1;
        sent_b.push_back(tx_data);
        sent_s.push_back(grant);
        ucnt = 0;
        udly = $urandom_range(1, 4);
      end else ucnt++;
    end
  end

  // protocol monitor
  always @(negedge clock) begin
    cyc++;
    if (tx_start && !prev_start) begin
      rises++;
      if (last_done >= 0 && cyc - last_done != 4) gap_bad++;
      last_done = -1;
    end
    prev_start = tx_start;
    if (tx_done) last_done = cyc;
    if (state == 3'd5 || pkt_done || reset) last_done = -1;
    if (at_rd_en) at_rds++;
    if (sen_rd_en) sen_rds++;
    if (at_rd_en && sen_rd_en) both_rd++;
    if (pkt_done) pkts++;
    if (state != 3'd0 && grant != 2'b01 && grant != 2'b10) bad_gnt++;
    if (busy != (state != 3'd0)) bad_gnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_pkts(input string tag, input int target, input int budget);
    int n = 0;
    while ((pkts < target || state != 3'd0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_wait"}, 32'(n < budget), 1);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int n = 0;
    while (state != s && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_wait"}, 32'(state), 32'(s));
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_len"}, sent_b.size(), exp_b.size());
    for (int i = 0; i < sent_b.size() && i < exp_b.size(); i++) begin
      check({tag, "_byte"}, sent_b[i], exp_b[i]);
      check({tag, "_src"}, sent_s[i], exp_s[i]);
    end
    sent_b.delete(); sent_s.delete(); exp_b.delete(); exp_s.delete();
  endtask

  task automatic push_sen(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      sen_q.push_back(b);
      exp_b.push_back(b);
      exp_s.push_back(2'b10);
    end
  endtask

  task automatic push_at(input logic [7:0] b);
    at_q.push_back(b);
    exp_b.push_back(b);
    exp_s.push_back(2'b01);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_ptr = 0;
  endtask

  initial begin
    int p0, r0, a0, s0, n, at_bytes, sp_rem, len;
    logic [7:0] b;
    logic pick_at;
    tick(3);
    check("rst_state", state, 0);
    check("rst_grant", grant, 0);
    check("rst_strobes", {tx_start, at_rd_en, sen_rd_en, pkt_done, busy}, 0);
    check("rst_err", timeout_err, 0);
    check("rst_txdata", tx_data, 0);
    reset = 1'b0;
    tick(1);

    push_sen(8);
    tick(2);
    p0 = pkts; r0 = rises; a0 = at_rds; s0 = sen_rds;
    enable = 1'b1;
    n = 0;
    while (!tx_start && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("latency", n, 3);
    wait_pkts("sen", p0 + 1, 500);
    check("sen_starts", rises - r0, 8);
    check("sen_rd", sen_rds - s0, 8);
    check("sen_at_rd", at_rds - a0, 0);
    check("sen_pkts", pkts - p0, 1);
    cmp_stream("sen");

    p0 = pkts; a0 = at_rds;
    push_at(8'h41); push_at(8'h54); push_at(8'h0D); push_at(8'h0A);
    wait_pkts("at1", p0 + 1, 500);
    tick(10);
    check("at1_pkts", pkts - p0, 1);
    check("at1_rd", at_rds - a0, 4);
    cmp_stream("at1");
    p0 = pkts;
    push_at(8'h41); push_at(8'h54); push_at(8'h0D); push_at(8'h58); push_at(8'h0D); push_at(8'h0A);
    wait_pkts("at2", p0 + 1, 500);
    tick(30);
    check("at2_pkts", pkts - p0, 1);
    cmp_stream("at2");

    enable = 1'b0;
    pulse_reset();
    at_bytes = 0;
    for (int k = 0; k < 3; k++) begin
      len = $urandom_range(0, 4);
      for (int j = 0; j < len; j++) begin
        b = 8'($urandom_range(32, 126));
        at_q.push_back(b); at_all.push_back(b);
      end
      at_q.push_back(8'h0D); at_all.push_back(8'h0D);
      at_q.push_back(8'h0A); at_all.push_back(8'h0A);
      at_len.push_back(len + 2);
      at_bytes += len + 2;
      for (int j = 0; j < 8; j++) begin
        b = 8'($urandom);
        sen_q.push_back(b); sen_all.push_back(b);
      end
    end
    sp_rem = 3;
    while (at_len.size() > 0 || sp_rem > 0) begin
      pick_at = at_len.size() > 0 && (sp_rem == 0 || exp_ptr == 0);
      if (pick_at) begin
        len = at_len.pop_front();
        repeat (len) begin exp_b.push_back(at_all.pop_front()); exp_s.push_back(2'b01); end
        exp_ptr = 1;
      end else begin
        repeat (8) begin exp_b.push_back(sen_all.pop_front()); exp_s.push_back(2'b10); end
        sp_rem--;
        exp_ptr = 0;
      end
    end
    tick(2);
    p0 = pkts; r0 = rises; a0 = at_rds; s0 = sen_rds;
    tick(100);
    check("dis_rd", (at_rds - a0) + (sen_rds - s0), 0);
    check("dis_start", rises - r0, 0);
    check("dis_state", state, 0);
    enable = 1'b1;
    n = 0;
    while (!tx_start && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("mix_start", tx_start, 1);
    enable = 1'b0;
    wait_pkts("mix_drop", p0 + 1, 2000);
    tick(20);
    check("drop_pkts", pkts - p0, 1);
    check("drop_idle", state, 0);
    enable = 1'b1;
    wait_pkts("mix", p0 + 6, 8000);
    check("mix_at_rd", at_rds - a0, at_bytes);
    check("mix_sen_rd", sen_rds - s0, 24);
    cmp_stream("mix");

    pulse_reset();
    p0 = pkts;
    push_sen(3);
    wait_state("stall1", 3'd5, 500);
    n = 0;
    while (!timeout_err && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("to_cycles", n, 16);
    check("to_grant", grant, 0);
    check("to_state", state, 0);
    check("to_nopkt", pkts - p0, 0);
    cmp_stream("to");
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check("clr_err", timeout_err, 0);

    push_sen(3);
    wait_state("stall2", 3'd5, 500);
    clear_err = 1'b1;
    n = 0;
    while (!timeout_err && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("to_prio_cycles", n, 16);
    clear_err = 1'b0;
    tick(1);
    check("to_sticky", timeout_err, 1);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check("clr_err2", timeout_err, 0);
    cmp_stream("to2");

    p0 = pkts;
    push_sen(3);
    wait_state("stall3", 3'd5, 500);
    tick(10);
    push_sen(5);
    wait_pkts("resume", p0 + 1, 1000);
    check("resume_err", timeout_err, 0);
    check("resume_pkts", pkts - p0, 1);
    cmp_stream("resume");

    push_sen(8);
    n = 0;
    while (!tx_start && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("rs_send", state, 3);
    reset = 1'b1;
    enable = 1'b0;
    tick(1);
    check("rs_txstart", tx_start, 0);
    check("rs_grant", grant, 0);
    check("rs_state", state, 0);
    check("rs_rd", {at_rd_en, sen_rd_en}, 0);
    check("rs_txdata", tx_data, 0);
    reset = 1'b0;
    sen_q.delete(); sent_b.delete(); sent_s.delete(); exp_b.delete(); exp_s.delete();
    tick(5);

    check("both_rd", both_rd, 0);
    check("byte_gap", gap_bad, 0);
    check("grant_busy", bad_gnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
